// File: rtl/rf_pkg.sv
`default_nettype none
// rf_pkg: register-file geometry, writeback requester indices and an index-width helper.
package rf_pkg;
   localparam int RF_AW       = 5;
   localparam int RF_DW       = 32;
   localparam int RF_ZERO_REG = 0;

   localparam int WB_ALU = 0;
   localparam int WB_MEM = 1;

   // Width of a requester index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// rr_grant: combinational round-robin pick, searching from last+1 upward modulo NREQ.
module rr_grant
   import rf_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = idx_w(NREQ)
)
(
   input  logic [NREQ-1:0] req_valid,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      // k = NREQ wraps back to last itself, so a lone requester always wins.
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// wb_port_arbiter: round-robin share of the register-file write port, one-cycle
// registered write stage, and forwarding of that pending write to the decode operands.
module wb_port_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW
)
(
   input  logic             clk_Regs,
   input  logic             rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic             Reg_Write,
   output logic [AW-1:0]    W_Addr,
   output logic [DW-1:0]    W_Data,
   input  logic [AW-1:0]    R_Addr_A,
   input  logic [AW-1:0]    R_Addr_B,
   input  logic [DW-1:0]    rf_data_a,
   input  logic [DW-1:0]    rf_data_b,
   output logic [DW-1:0]    op_data_a,
   output logic [DW-1:0]    op_data_b
);

   localparam int IW = idx_w(NREQ);

   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            xfer;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   logic            reg_write_q, reg_write_d;
   logic [AW-1:0]   w_addr_q, w_addr_d;
   logic [DW-1:0]   w_data_q, w_data_d;
   logic [IW-1:0]   last_q, last_d;

   logic            hit_a, hit_b;

   rr_grant #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_grant (
      .req_valid (req_valid),
      .last      (last_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx)
   );

   // Grants are suppressed while reset is held so no requester believes it was accepted.
   assign req_ready = rst_n ? gnt : '0;
   assign xfer      = |req_ready;
   assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
   assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];

   always_comb begin
      reg_write_d = 1'b0;
      w_addr_d    = w_addr_q;
      w_data_d    = w_data_q;
      last_d      = last_q;
      if (xfer) begin
         reg_write_d = (sel_addr != AW'(RF_ZERO_REG));
         w_addr_d    = sel_addr;
         w_data_d    = sel_data;
         last_d      = gnt_idx;
      end
   end

   always_ff @(posedge clk_Regs or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_q <= 1'b0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         last_q      <= IW'(NREQ - 1);
      end else begin
         reg_write_q <= reg_write_d;
         w_addr_q    <= w_addr_d;
         w_data_q    <= w_data_d;
         last_q      <= last_d;
      end
   end

   assign Reg_Write = reg_write_q;
   assign W_Addr    = w_addr_q;
   assign W_Data    = w_data_q;

   assign hit_a     = reg_write_q && (w_addr_q == R_Addr_A) && (R_Addr_A != AW'(RF_ZERO_REG));
   assign hit_b     = reg_write_q && (w_addr_q == R_Addr_B) && (R_Addr_B != AW'(RF_ZERO_REG));
   assign op_data_a = hit_a ? w_data_q : rf_data_a;
   assign op_data_b = hit_b ? w_data_q : rf_data_b;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// tb_wb_port_arbiter: directed vector table, constrained-random run against a
// behavioural model, and an asynchronous mid-write reset sequence.
module tb_wb_port_arbiter;
   import rf_pkg::*;

   localparam int NREQ = 2;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic               clk;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic               Reg_Write;
   logic [AW-1:0]      W_Addr;
   logic [DW-1:0]      W_Data;
   logic [AW-1:0]      R_Addr_A, R_Addr_B;
   logic [DW-1:0]      rf_data_a, rf_data_b;
   logic [DW-1:0]      op_data_a, op_data_b;

   wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk_Regs  (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .Reg_Write (Reg_Write),
      .W_Addr    (W_Addr),
      .W_Data    (W_Data),
      .R_Addr_A  (R_Addr_A),
      .R_Addr_B  (R_Addr_B),
      .rf_data_a (rf_data_a),
      .rf_data_b (rf_data_b),
      .op_data_a (op_data_a),
      .op_data_b (op_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [4:0]  ra;
      logic [31:0] rfa;
      logic [4:0]  rb;
      logic [31:0] rfb;
      logic [1:0]  rdy;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] opa;
      logic [31:0] opb;
   } row_t;

   localparam int NROWS = 15;
   row_t tbl [NROWS];

   // Round-robin reference: first valid index above last, else the lowest valid index.
   function automatic int exp_grant(input logic [NREQ-1:0] v, input int last);
      for (int i = last + 1; i < NREQ; i++) if (v[i]) return i;
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   int          m_last;
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic [31:0] rf [32];

   function automatic logic [31:0] fwd(input logic [4:0] ra);
      if (ra == 5'd0) return 32'd0;
      if (m_we && m_waddr == ra) return m_wdata;
      return rf[ra];
   endfunction

   initial begin
      logic        pend [NREQ];
      logic [4:0]  pa   [NREQ];
      logic [31:0] pd   [NREQ];
      int          wt   [NREQ];
      int          g;
      logic [NREQ-1:0] v;

      //                valid  a0    d0            a1    d1        ra    rfa         rb    rfb      rdy    we    wa    wd            opa           opb
      tbl[0]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd7, 32'hAAAA, 5'd0, 32'h0,  2'b00, 1'b0, 5'd0, 32'h0,        32'hAAAA,     32'h0};
      tbl[1]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,    5'd5, 32'h0,    5'd0, 32'h0,  2'b01, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};
      tbl[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd5, 32'h0,    5'd5, 32'h77, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[3]  = '{2'b11, 5'd1, 32'h100,      5'd2, 32'h200,  5'd1, 32'h9,    5'd2, 32'h8,  2'b10, 1'b0, 5'd5, 32'hDEADBEEF, 32'h9,        32'h8};
      tbl[4]  = '{2'b11, 5'd1, 32'h100,      5'd2, 32'h200,  5'd1, 32'h9,    5'd2, 32'h8,  2'b01, 1'b1, 5'd2, 32'h200,      32'h9,        32'h200};
      tbl[5]  = '{2'b11, 5'd1, 32'h100,      5'd2, 32'h200,  5'd1, 32'h9,    5'd2, 32'h8,  2'b10, 1'b1, 5'd1, 32'h100,      32'h100,      32'h8};
      tbl[6]  = '{2'b11, 5'd1, 32'h100,      5'd2, 32'h200,  5'd1, 32'h9,    5'd2, 32'h8,  2'b01, 1'b1, 5'd2, 32'h200,      32'h9,        32'h200};
      tbl[7]  = '{2'b11, 5'd1, 32'h100,      5'd2, 32'h200,  5'd1, 32'h9,    5'd2, 32'h8,  2'b10, 1'b1, 5'd1, 32'h100,      32'h100,      32'h8};
      tbl[8]  = '{2'b11, 5'd1, 32'h100,      5'd2, 32'h200,  5'd1, 32'h9,    5'd2, 32'h8,  2'b01, 1'b1, 5'd2, 32'h200,      32'h9,        32'h200};
      tbl[9]  = '{2'b10, 5'd0, 32'h0,        5'd0, 32'h1234, 5'd1, 32'h9,    5'd0, 32'h0,  2'b10, 1'b1, 5'd1, 32'h100,      32'h100,      32'h0};
      tbl[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd0, 32'h0,    5'd0, 32'h0,  2'b00, 1'b0, 5'd0, 32'h1234,     32'h0,        32'h0};
      tbl[11] = '{2'b01, 5'd3, 32'h11,       5'd0, 32'h0,    5'd3, 32'h0,    5'd0, 32'h0,  2'b01, 1'b0, 5'd0, 32'h1234,     32'h0,        32'h0};
      tbl[12] = '{2'b10, 5'd0, 32'h0,        5'd3, 32'h22,   5'd3, 32'h0,    5'd3, 32'h0,  2'b10, 1'b1, 5'd3, 32'h11,       32'h11,       32'h11};
      tbl[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd3, 32'h11,   5'd3, 32'h11, 2'b00, 1'b1, 5'd3, 32'h22,       32'h22,       32'h22};
      tbl[14] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd3, 32'h22,   5'd3, 32'h22, 2'b00, 1'b0, 5'd3, 32'h22,       32'h22,       32'h22};

      rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      R_Addr_A  = '0;
      R_Addr_B  = '0;
      rf_data_a = '0;
      rf_data_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- directed table ----------------
      for (int r = 0; r < NROWS; r++) begin
         @(negedge clk);
         req_valid = tbl[r].valid;
         req_addr  = {tbl[r].a1, tbl[r].a0};
         req_data  = {tbl[r].d1, tbl[r].d0};
         R_Addr_A  = tbl[r].ra;
         R_Addr_B  = tbl[r].rb;
         rf_data_a = tbl[r].rfa;
         rf_data_b = tbl[r].rfb;
         #1;
         chk($sformatf("row%0d_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
         chk($sformatf("row%0d_we", r),    64'(Reg_Write), 64'(tbl[r].we));
         chk($sformatf("row%0d_waddr", r), 64'(W_Addr),    64'(tbl[r].wa));
         chk($sformatf("row%0d_wdata", r), 64'(W_Data),    64'(tbl[r].wd));
         chk($sformatf("row%0d_opa", r),   64'(op_data_a), 64'(tbl[r].opa));
         chk($sformatf("row%0d_opb", r),   64'(op_data_b), 64'(tbl[r].opb));
      end

      // ---------------- randomized run against model ----------------
      m_last  = 1;
      m_we    = 1'b0;
      m_waddr = 5'd3;
      m_wdata = 32'h22;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[3] = 32'h22;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0; pa[i] = '0; pd[i] = '0; wt[i] = 0;
      end

      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 65) begin
               pend[i] = 1'b1;
               pa[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
               pd[i]   = $urandom;
            end
         end
         for (int i = 0; i < NREQ; i++) v[i] = pend[i];
         req_valid = v;
         req_addr  = {pa[1], pa[0]};
         req_data  = {pd[1], pd[0]};
         case ($urandom_range(0, 3))
            0:       R_Addr_A = m_waddr;
            1:       R_Addr_A = 5'd0;
            default: R_Addr_A = 5'($urandom_range(0, 7));
         endcase
         R_Addr_B  = ($urandom_range(0, 1) == 0) ? m_waddr : 5'($urandom_range(0, 7));
         rf_data_a = rf[R_Addr_A];
         rf_data_b = rf[R_Addr_B];
         #1;
         g = exp_grant(v, m_last);
         chk("rnd_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
         chk("rnd_we",    64'(Reg_Write), 64'(m_we));
         chk("rnd_waddr", 64'(W_Addr),    64'(m_waddr));
         chk("rnd_wdata", 64'(W_Data),    64'(m_wdata));
         chk("rnd_opa",   64'(op_data_a), 64'(fwd(R_Addr_A)));
         chk("rnd_opb",   64'(op_data_b), 64'(fwd(R_Addr_B)));
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i] && i != g) wt[i]++;
            if (i == g) begin
               chk("rnd_starve", 64'(wt[i] <= NREQ - 1), 64'd1);
               wt[i] = 0;
            end
         end
         @(posedge clk);
         if (m_we) rf[m_waddr] = m_wdata;
         if (g >= 0) begin
            m_we    = (pa[g] != 5'd0);
            m_waddr = pa[g];
            m_wdata = pd[g];
            m_last  = g;
            pend[g] = 1'b0;
         end else begin
            m_we = 1'b0;
         end
      end

      // ---------------- asynchronous reset during a pending write ----------------
      @(negedge clk);
      req_valid = 2'b01;
      req_addr  = {5'd0, 5'd9};
      req_data  = {32'h0, 32'hABC};
      @(posedge clk);
      #3;
      chk("rst_pre_we",    64'(Reg_Write), 64'd1);
      chk("rst_pre_waddr", 64'(W_Addr),    64'd9);
      rst_n = 1'b0;
      #1;
      chk("rst_we",    64'(Reg_Write), 64'd0);
      chk("rst_waddr", 64'(W_Addr),    64'd0);
      chk("rst_wdata", 64'(W_Data),    64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_we", 64'(Reg_Write), 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 2'b11;
      req_addr  = {5'd6, 5'd4};
      req_data  = {32'h66, 32'h44};
      #1;
      chk("post_rst_ready0", 64'(req_ready), 64'd1 << WB_ALU);
      @(negedge clk);
      #1;
      chk("post_rst_ready1", 64'(req_ready), 64'd1 << WB_MEM);
      chk("post_rst_we",     64'(Reg_Write), 64'd1);
      chk("post_rst_waddr0", 64'(W_Addr),    64'd4);
      chk("post_rst_wdata0", 64'(W_Data),    64'h44);
      @(negedge clk);
      #1;
      chk("post_rst_ready2", 64'(req_ready), 64'd1 << WB_ALU);
      chk("post_rst_waddr1", 64'(W_Addr),    64'd6);
      chk("post_rst_wdata1", 64'(W_Data),    64'h66);
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port among several writeback requesters (requester 0 = ALU result, requester 1 = memory load) in round-robin order. It also holds the granted write for one cycle before the register file commits it. While that write is pending, it forwards the value to the decode-stage read operands. It sits between the execute/memory writeback sources and `reg_file32`. It directly drives `Reg_Write`, `W_Addr` and `W_Data`, and post-processes `R_Data_A` and `R_Data_B`.

## Interface
Parameters:
- `NREQ`, default 2: number of writeback requesters, range 2..4.
- `AW`, default 5: register address width.
- `DW`, default 32: data width.

Ports:
- `clk_Regs`  in  1  clock shared with the register file.
- `rst_n`  in  1  reset. Asynchronous and active-low.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_ready`  out  NREQ  requester i is granted this cycle. One-hot or zero.
- `req_addr`  in  NREQ*AW  destination register; slice i belongs to requester i.
- `req_data`  in  NREQ*DW  write data; slice i belongs to requester i.
- `Reg_Write`  out  1  registered write enable to the register file.
- `W_Addr`  out  AW  registered write address.
- `W_Data`  out  DW  registered write data.
- `R_Addr_A`, `R_Addr_B`  in  AW  decode read addresses. These are also routed to the register file.
- `rf_data_a`, `rf_data_b`  in  DW  register file `R_Data_A` and `R_Data_B`.
- `op_data_a`, `op_data_b`  out  DW  forwarded operands.

## Operation
Arbitration:
- A round-robin pointer `last` holds the index of the most recently granted requester.
- Search order is `last+1`, `last+2`, … modulo NREQ. The first requester found with `req_valid` set receives `req_ready`.
- `req_ready` is combinational from `req_valid` and `last`.
- `req_ready[i]` never asserts unless `req_valid[i]` is set.
- A transfer occurs when both `req_valid[i]` and `req_ready[i]` are set. Exactly zero or one transfer occurs per cycle.

On a transfer, at the clock edge:
- `W_Addr` <= `req_addr[i]`.
- `W_Data` <= `req_data[i]`.
- `Reg_Write` <= (`req_addr[i]` != 0).
- `last` <= i.

A write to register 0 is therefore accepted and consumed, but never asserts `Reg_Write`.

With no transfer:
- `Reg_Write` <= 0.
- `W_Addr`, `W_Data` and `last` hold their values.

Requester-side protocol:
- A requester must hold `addr` and `data` stable while valid is high and ready is low.
- Once a requester asserts valid, it must keep valid high until ready is granted.

Forwarding, for each of ports A and B:
- `op_data_x` = `W_Data` when `Reg_Write` is set, `W_Addr` == `R_Addr_x`, and `R_Addr_x` != 0.
- Otherwise `op_data_x` = `rf_data_x`.
- `R_Addr_x` == 0 always yields 0, taken from `rf_data_x`.

## Timing
- Reset values: `Reg_Write`=0, `W_Addr`=0, `W_Data`=0, `last`=NREQ-1, so requester 0 wins first.
- While `rst_n` is low, `req_ready` is 0.
- Reset mid-operation clears any pending write. The write is not committed, and the requester must re-present it.
- Latency: a request accepted at edge k drives `Reg_Write` during cycle k..k+1. The register file commits the write at edge k+1.
- Forwarding covers exactly the window between edge k and edge k+1.
- Throughput: one write per cycle.
- Starvation bound: with all requesters continuously valid, a requester waits at most NREQ-1 cycles.
- Back-to-back writes to the same register: the second write overwrites the first. Forwarding always shows the newest registered value.
- Simultaneous request from all requesters right after reset: requester 0 is served, then 1, and so on.
- A lone requester is granted every cycle regardless of `last`.

## Structure
- Shared package `rf_pkg`:
  - constants `RF_AW`=5, `RF_DW`=32, `RF_ZERO_REG`=0.
  - requester index constants `WB_ALU`=0, `WB_MEM`=1.
- One sub-module, `rr_grant`:
  - purely combinational.
  - inputs: `req_valid`, `last`.
  - outputs: one-hot grant and the encoded index.
- `wb_port_arbiter` holds the output registers, the `last` pointer, and the forward muxes.

## Test plan
1. Reset, then hold all `req_valid`=0 → `Reg_Write`=0, `W_Addr`=0, `W_Data`=0, `op_data_a`=`rf_data_a`.
2. Single write: requester 0 valid with addr 5, data 0xDEADBEEF → `req_ready[0]`=1 in the same cycle. The next cycle shows `Reg_Write`=1, `W_Addr`=5, `W_Data`=0xDEADBEEF. With `R_Addr_A`=5 and `rf_data_a`=0, `op_data_a`=0xDEADBEEF.
3. Both requesters continuously valid for 6 cycles → grants alternate 0,1,0,1,0,1, and each grant is visible on `W_Addr`/`W_Data` one cycle later.
4. Requester 1 valid with addr 0, data 0x1234 → ready is granted, `Reg_Write` stays 0, and `op_data_b` with `R_Addr_B`=0 remains 0.
5. Sequence:
   - Requester 0 writes reg 3 = 0x11 in cycle k.
   - Requester 1 writes reg 3 = 0x22 in cycle k+1.
   - Expected: `op_data_a` (`R_Addr_A`=3) forwards 0x11, then 0x22.
   - Expected: the register file finally holds 0x22.
6. Assert `rst_n`=0 asynchronously mid-cycle while a write is pending → `Reg_Write` drops immediately with no commit. After release, requester 0 has priority.
